// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, byte receive and transmit over an
// oversampled, synchronised SCL/SDA pair in the clk domain.
module i2c_target #(
    parameter logic [6:0] ADDRESS     = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       addressed,
    output logic       restart_det
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_p, sda_p;
    logic scl_rise, scl_fall, start, stop;

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] shift, shift_n, rx_data_n, byte_in;
    logic       rw, rw_n, oe_n, rx_valid_n, busy_n, addr_n, rs_n, load_tx;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    assign scl_rise = scl_s & ~scl_p;
    assign scl_fall = ~scl_s & scl_p;
    assign start    = scl_s & scl_p & sda_p & ~sda_s;
    assign stop     = scl_s & scl_p & ~sda_p & sda_s;
    assign byte_in  = {shift[6:0], sda_s};
    assign tx_req   = load_tx & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_p    <= scl_s;
            sda_p    <= sda_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            shift       <= 8'h00;
            rw          <= 1'b0;
            sda_oe      <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            addressed   <= 1'b0;
            restart_det <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            shift       <= shift_n;
            rw          <= rw_n;
            sda_oe      <= oe_n;
            rx_data     <= rx_data_n;
            rx_valid    <= rx_valid_n;
            busy        <= busy_n;
            addressed   <= addr_n;
            restart_det <= rs_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shift_n    = shift;
        rw_n       = rw;
        oe_n       = sda_oe;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        busy_n     = busy;
        addr_n     = addressed;
        rs_n       = 1'b0;
        load_tx    = 1'b0;
        if (start) begin
            state_n = ADDR;
            cnt_n   = 3'd0;
            shift_n = 8'h00;
            busy_n  = 1'b1;
            addr_n  = 1'b0;
            rs_n    = busy;
        end else if (stop) begin
            state_n = IDLE;
            cnt_n   = 3'd0;
            busy_n  = 1'b0;
            addr_n  = 1'b0;
            oe_n    = 1'b0;
        end else begin
            unique case (state)
                ADDR: if (scl_rise) begin
                    shift_n = byte_in;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (byte_in[7:1] == ADDRESS) begin
                            addr_n  = 1'b1;
                            rw_n    = byte_in[0];
                            state_n = ADDR_ACK;
                        end else begin
                            state_n = IDLE;
                            oe_n    = 1'b0;
                        end
                    end
                end
                // sda_oe doubles as the phase flag: low = ACK not yet driven
                ADDR_ACK, RX_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        oe_n = 1'b1;
                    end else if (state == RX_ACK || !rw) begin
                        oe_n    = 1'b0;
                        cnt_n   = 3'd0;
                        state_n = RX_BYTE;
                    end else begin
                        load_tx = 1'b1;
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    shift_n = byte_in;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        rx_data_n  = byte_in;
                        rx_valid_n = 1'b1;
                        state_n    = RX_ACK;
                    end
                end
                TX_BYTE: if (scl_fall) begin
                    if (cnt == 3'd7) begin
                        oe_n    = 1'b0;
                        cnt_n   = 3'd0;
                        state_n = TX_ACK;
                    end else begin
                        oe_n    = ~shift[7];
                        shift_n = {shift[6:0], 1'b0};
                        cnt_n   = cnt + 3'd1;
                    end
                end
                // cnt == 1 records that the controller acknowledged
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_n = IDLE;
                            addr_n  = 1'b0;
                        end else begin
                            cnt_n = 3'd1;
                        end
                    end else if (scl_fall && cnt == 3'd1) begin
                        load_tx = 1'b1;
                    end
                end
                default: ;
            endcase
            if (load_tx) begin
                oe_n    = ~tx_data[7];
                shift_n = {tx_data[6:0], 1'b0};
                cnt_n   = 3'd0;
                state_n = TX_BYTE;
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bus controller model drives
// write/read/restart/reset/stop sequences; scoreboards track rx and tx bytes.
module tb_i2c_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       m_scl, m_sda;
    logic       sda_oe, rx_valid, tx_req, busy, addressed, restart_det;
    logic [7:0] rx_data, tx_data;
    logic       bus_sda;

    assign bus_sda = m_sda & ~sda_oe;

    i2c_target #(.ADDRESS(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset(reset),
        .scl_in(m_scl),
        .sda_in(bus_sda),
        .sda_oe(sda_oe),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_data(tx_data),
        .tx_req(tx_req),
        .busy(busy),
        .addressed(addressed),
        .restart_det(restart_det)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int rs_cnt = 0;
    logic oe_seen = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] sent_q[$];

    typedef struct {
        string      name;
        logic [7:0] addr;
        logic [7:0] data;
        logic       addr_ack;
        logic       data_ack;
    } wvec_t;

    wvec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (sda_oe) oe_seen = 1'b1;
            if (rx_valid) begin
                rx_cnt++;
                if (rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_data);
                end else begin
                    chk("rx_data", {24'h0, rx_data}, {24'h0, rx_q.pop_front()});
                end
            end
            if (tx_req) begin
                tx_cnt++;
                sent_q.push_back(tx_data);
            end
            if (restart_det) rs_cnt++;
        end
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b0; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wq();
        m_scl = 1'b1; wq();
        m_sda = 1'b1; wq();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wq();
        m_scl = 1'b1; wq(); wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        m_sda = 1'b1; wq();
        m_scl = 1'b1; wq();
        ack = ~bus_sda; wq();
        m_scl = 1'b0; wq();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        d = 8'h00;
        m_sda = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wq();
            m_scl = 1'b1; wq();
            d = {d[6:0], bus_sda}; wq();
            m_scl = 1'b0; wq();
        end
        write_bit(nack);
    endtask

    task automatic chk_read(input string nm, input logic [7:0] d);
        chk({nm, "_byte"}, {24'h0, d}, 32'h96);
        if (sent_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_sb: got %0h expected a tx_req first", nm, d);
        end else begin
            chk({nm, "_sb"}, {24'h0, d}, {24'h0, sent_q.pop_front()});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic a1, a2;
        logic [7:0] d;
        int t0, r0, x0;

        vecs[0] = '{"wr3c",  8'hA0, 8'h3C, 1'b1, 1'b1};
        vecs[1] = '{"mis_a2", 8'hA2, 8'h55, 1'b0, 1'b0};
        vecs[2] = '{"wrff",  8'hA0, 8'hFF, 1'b1, 1'b1};
        vecs[3] = '{"wr00",  8'hA0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{"mis_20", 8'h20, 8'h81, 1'b0, 1'b0};

        reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1; tx_data = 8'h96;
        repeat (5) @(negedge clk);
        chk("rst_oe", {31'h0, sda_oe}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_addr", {31'h0, addressed}, 32'h0);
        chk("rst_rxd", {24'h0, rx_data}, 32'h0);
        chk("rst_txreq", {31'h0, tx_req}, 32'h0);
        reset = 1'b0;
        wq();

        for (int k = 0; k < 5; k++) begin
            oe_seen = 1'b0;
            if (vecs[k].addr_ack) rx_q.push_back(vecs[k].data);
            i2c_start();
            chk({vecs[k].name, "_busy"}, {31'h0, busy}, 32'h1);
            write_byte(vecs[k].addr, a1);
            write_byte(vecs[k].data, a2);
            chk({vecs[k].name, "_aack"}, {31'h0, a1}, {31'h0, vecs[k].addr_ack});
            chk({vecs[k].name, "_dack"}, {31'h0, a2}, {31'h0, vecs[k].data_ack});
            chk({vecs[k].name, "_addressed"}, {31'h0, addressed},
                {31'h0, vecs[k].addr_ack});
            chk({vecs[k].name, "_oe_seen"}, {31'h0, oe_seen},
                {31'h0, vecs[k].addr_ack});
            i2c_stop();
            wq();
            chk({vecs[k].name, "_idle"}, {31'h0, busy}, 32'h0);
            chk({vecs[k].name, "_rxq"}, rx_q.size(), 32'h0);
        end

        // read: controller ACKs the first byte, NACKs the second
        t0 = tx_cnt;
        i2c_start();
        write_byte(8'hA1, a1);
        chk("rd_aack", {31'h0, a1}, 32'h1);
        read_byte(1'b0, d);
        chk_read("rd1", d);
        read_byte(1'b1, d);
        chk_read("rd2", d);
        wq();
        chk("rd_txreq", tx_cnt - t0, 32'd2);
        chk("rd_addressed", {31'h0, addressed}, 32'h0);
        chk("rd_busy", {31'h0, busy}, 32'h1);
        chk("rd_oe", {31'h0, sda_oe}, 32'h0);
        i2c_stop();
        wq();
        chk("rd_idle", {31'h0, busy}, 32'h0);

        // repeated start: write 0x01, then restart into a read
        r0 = rs_cnt;
        i2c_start();
        chk("rs_first", rs_cnt - r0, 32'd0);
        write_byte(8'hA0, a1);
        rx_q.push_back(8'h01);
        write_byte(8'h01, a2);
        chk("rs_wack", {31'h0, a1 & a2}, 32'h1);
        i2c_start();
        chk("rs_pulse", rs_cnt - r0, 32'd1);
        write_byte(8'hA1, a1);
        chk("rs_aack", {31'h0, a1}, 32'h1);
        chk("rs_addressed", {31'h0, addressed}, 32'h1);
        read_byte(1'b1, d);
        chk_read("rs_rd", d);
        i2c_stop();
        wq();
        chk("rs_rxq", rx_q.size(), 32'h0);
        chk("rs_idle", {31'h0, busy}, 32'h0);

        // reset during bit 4 of a data byte, then the bus is ignored
        i2c_start();
        write_byte(8'hA0, a1);
        write_bit(1'b0); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
        m_sda = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_oe", {31'h0, sda_oe}, 32'h0);
        chk("mr_rxd", {24'h0, rx_data}, 32'h0);
        chk("mr_rxv", {31'h0, rx_valid}, 32'h0);
        chk("mr_busy", {31'h0, busy}, 32'h0);
        chk("mr_addr", {31'h0, addressed}, 32'h0);
        chk("mr_rs", {31'h0, restart_det}, 32'h0);
        chk("mr_txreq", {31'h0, tx_req}, 32'h0);
        oe_seen = 1'b0;
        wq();
        write_byte(8'hA0, a1);
        chk("mr_noack", {31'h0, a1}, 32'h0);
        chk("mr_oe_seen", {31'h0, oe_seen}, 32'h0);
        rx_q.push_back(8'h3C);
        i2c_start();
        write_byte(8'hA0, a1);
        write_byte(8'h3C, a2);
        chk("mr_wack", {31'h0, a1 & a2}, 32'h1);
        i2c_stop();
        wq();
        chk("mr_rxq", rx_q.size(), 32'h0);
        chk("mr_idle", {31'h0, busy}, 32'h0);

        // STOP after 3 data bits
        x0 = rx_cnt;
        i2c_start();
        write_byte(8'hA0, a1);
        write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        wq();
        chk("ms_busy", {31'h0, busy}, 32'h0);
        chk("ms_oe", {31'h0, sda_oe}, 32'h0);
        chk("ms_addr", {31'h0, addressed}, 32'h0);
        chk("ms_norx", rx_cnt - x0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter ADDRESS, default 7'h50: 7-bit target address this block responds to.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth on scl_in and sda_in; legal range 2..4.
REQ-003 clk  input  1  system clock; the single clock domain of the block.
REQ-004 reset  input  1  reset, synchronous to clk, active-high.
REQ-005 scl_in  input  1  raw bus SCL level, asynchronous to clk.
REQ-006 sda_in  input  1  raw bus SDA level, asynchronous to clk.
REQ-007 sda_oe  output  1  1 pulls SDA low (open-drain); 0 releases SDA.
REQ-008 rx_data  output  8  last byte received from the controller.
REQ-009 rx_valid  output  1  one-cycle pulse; rx_data is valid in that cycle.
REQ-010 tx_data  input  8  byte to send on a read transfer; sampled on tx_req.
REQ-011 tx_req  output  1  one-cycle pulse; the block latches tx_data in this same cycle.
REQ-012 busy  output  1  high from a detected START until the next detected STOP.
REQ-013 addressed  output  1  high while the current transfer matches ADDRESS.
REQ-014 restart_det  output  1  one-cycle pulse when a repeated START is detected while busy.

Function
REQ-015 scl_in and sda_in shall each pass through SYNC_STAGES flops; all logic shall use only the synchronised values (scl_s, sda_s) and their previous-cycle copies.
REQ-016 SCL rise and SCL fall are single-cycle events, detected from scl_s against its previous-cycle value.
REQ-017 START: sda_s falls while scl_s is 1 and was 1 in the previous cycle.
REQ-018 STOP: sda_s rises while scl_s is 1 and was 1 in the previous cycle.
REQ-019 States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK.
REQ-020 START from any state shall clear the bit counter and shift register and enter ADDR.
REQ-021 START while busy is 1 shall additionally pulse restart_det for exactly one cycle.
REQ-022 STOP from any state shall enter IDLE, clear busy and addressed, and release sda_oe in the same cycle.
REQ-023 In ADDR, RX_BYTE and TX_ACK, SDA shall be sampled on SCL rise, MSB first, counting bits 0..7 with a 3-bit counter.
REQ-024 ADDR, after 8 bits: if bits[7:1] == ADDRESS, set addressed, latch R/W = bit0 and enter ADDR_ACK; otherwise enter IDLE with busy still 1 and ignore the bus until the next START or STOP.
REQ-025 ADDR_ACK: assert sda_oe=1 on the SCL fall after the 8th bit and hold it for one full SCL high phase.
REQ-026 ADDR_ACK exit, on the following SCL fall: R/W=0 -> RX_BYTE with sda_oe=0; R/W=1 -> pulse tx_req, latch tx_data, enter TX_BYTE.
REQ-027 RX_BYTE, after 8 bits: load rx_data, pulse rx_valid for one cycle, enter RX_ACK, which drives the ACK as in REQ-025; then return to RX_BYTE.
REQ-028 TX_BYTE: drive sda_oe = ~shift[7] after each SCL fall, shifting left; the first bit is driven on the fall that exits ADDR_ACK or TX_ACK.
REQ-029 TX_BYTE, after the 8th SCL fall: release sda_oe and enter TX_ACK.
REQ-030 TX_ACK, on SCL rise: sda_s=0 (ACK) -> on the next SCL fall pulse tx_req, latch tx_data, enter TX_BYTE; sda_s=1 (NACK) -> IDLE, addressed cleared.
REQ-031 sda_oe shall change only in the cycle of a detected SCL fall, except on STOP, reset or a non-matching address.
REQ-032 When START or STOP coincides with an SCL edge event in the same cycle, START/STOP takes priority.

Reset
REQ-033 On reset: state IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, addressed=0, restart_det=0, counters 0, synchroniser flops 1.
REQ-034 Reset asserted mid-transfer shall abort the transfer; after reset deasserts, the block ignores the bus until a new START.

Verification
REQ-035 Write: START, 0xA0, data 0x3C, STOP -> two ACKs (sda_oe=1 in both 9th clocks); rx_valid pulses once with rx_data=8'h3C; busy returns to 0.
REQ-036 Address mismatch: START, 0xA2, 0x55 -> sda_oe stays 0 throughout; rx_valid never pulses; addressed=0.
REQ-037 Read: START, 0xA1, tx_data=8'h96, controller ACKs then NACKs -> SDA carries 1001_0110 twice; tx_req pulses twice; the block ends in IDLE.
REQ-038 Repeated START: START, 0xA0, 0x01, then START, 0xA1 -> restart_det pulses once; the block enters ADDR and then transmits.
REQ-039 Reset asserted during bit 4 of a data byte -> all outputs match REQ-033 on the next cycle; a subsequent full write completes normally.
REQ-040 STOP mid-byte after 3 data bits -> state IDLE, sda_oe=0, no rx_valid pulse.
